// File: rtl/id_stage_if.sv
// Signal bundle between the IF/ID register, WB/EXE/MEM feedback and the ID stage.
// The slave modport is the decode stage; master is whoever drives it.
interface id_stage_if;
    logic [31:0] Instruction;
    logic [31:0] PC_IN;
    logic [3:0]  Status;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        EXE_WB_EN;
    logic [3:0]  EXE_Dest;
    logic        MEM_WB_EN;
    logic [3:0]  MEM_Dest;

    logic        Wb_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        B;
    logic        S;
    logic [3:0]  EXE_CMD;
    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic        C_out;
    logic        Hazard;

    modport master (
        output Instruction, PC_IN, Status, WB_WB_EN, WB_Dest, WB_Value,
               EXE_WB_EN, EXE_Dest, MEM_WB_EN, MEM_Dest,
        input  Wb_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, C_out, Hazard
    );

    modport slave (
        input  Instruction, PC_IN, Status, WB_WB_EN, WB_Dest, WB_Value,
               EXE_WB_EN, EXE_Dest, MEM_WB_EN, MEM_Dest,
        output Wb_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, C_out, Hazard
    );
endinterface

// File: rtl/id_stage.sv
// ARM pipeline decode stage: register file, control decode, condition check and
// RAW hazard detection against EXE/MEM. Purely combinational apart from the RF.
module id_stage #(
    parameter int unsigned RF_BYPASS = 1
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    localparam logic [3:0] OpMov = 4'b1101, OpMvn = 4'b1111;
    localparam logic [3:0] OpCmp = 4'b1010, OpTst = 4'b1000;

    logic [31:0] rf_q [16];

    logic [3:0] cond, opcode, rn, rd, rm, src2;
    logic [1:0] mode;
    logic       i_bit, s_bit, is_str;
    logic       byp_ok, cond_ok, ctrl_ok, hazard;
    logic       src1_used, src2_used, hit1, hit2;
    logic       wb, mr, mw, br, sf;
    logic [3:0] cmd;
    logic [31:0] val_rn, val_rm;

    assign cond   = bus.Instruction[31:28];
    assign mode   = bus.Instruction[27:26];
    assign i_bit  = bus.Instruction[25];
    assign opcode = bus.Instruction[24:21];
    assign s_bit  = bus.Instruction[20];
    assign rn     = bus.Instruction[19:16];
    assign rd     = bus.Instruction[15:12];
    assign rm     = bus.Instruction[3:0];
    assign is_str = (mode == 2'b01) && !s_bit;
    assign src2   = is_str ? rd : rm;

    // R15 is never stored; its reset value is irrelevant since reads return PC_IN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= 32'(i);
        end else if (bus.WB_WB_EN && bus.WB_Dest != 4'd15) begin
            rf_q[bus.WB_Dest] <= bus.WB_Value;
        end
    end

    assign byp_ok = (RF_BYPASS != 0) && bus.WB_WB_EN && !reset;

    always_comb begin
        if (rn == 4'd15)                      val_rn = bus.PC_IN;
        else if (byp_ok && bus.WB_Dest == rn) val_rn = bus.WB_Value;
        else                                  val_rn = rf_q[rn];
        if (src2 == 4'd15)                      val_rm = bus.PC_IN;
        else if (byp_ok && bus.WB_Dest == src2) val_rm = bus.WB_Value;
        else                                    val_rm = rf_q[src2];
    end

    always_comb begin
        cmd = 4'b0000;
        wb  = 1'b0;
        mr  = 1'b0;
        mw  = 1'b0;
        br  = 1'b0;
        sf  = 1'b0;
        case (mode)
            2'b00: begin
                sf = s_bit;
                wb = (opcode != OpCmp) && (opcode != OpTst);
                case (opcode)
                    4'b1101: cmd = 4'b0001;
                    4'b1111: cmd = 4'b1001;
                    4'b0100: cmd = 4'b0010;
                    4'b0101: cmd = 4'b0011;
                    4'b0010: cmd = 4'b0100;
                    4'b0110: cmd = 4'b0101;
                    4'b1010: cmd = 4'b0100;
                    4'b0000: cmd = 4'b0110;
                    4'b1000: cmd = 4'b0110;
                    4'b1100: cmd = 4'b0111;
                    4'b0001: cmd = 4'b1000;
                    default: cmd = 4'b0000;
                endcase
            end
            2'b01: begin
                cmd = 4'b0010;
                wb  = s_bit;
                mr  = s_bit;
                mw  = !s_bit;
            end
            2'b10:   br = 1'b1;
            default: ;
        endcase
    end

    // Status is {N,Z,C,V}
    always_comb begin
        case (cond)
            4'b0000: cond_ok = bus.Status[2];
            4'b0001: cond_ok = !bus.Status[2];
            4'b0010: cond_ok = bus.Status[1];
            4'b0011: cond_ok = !bus.Status[1];
            4'b0100: cond_ok = bus.Status[3];
            4'b0101: cond_ok = !bus.Status[3];
            4'b0110: cond_ok = bus.Status[0];
            4'b0111: cond_ok = !bus.Status[0];
            4'b1000: cond_ok = bus.Status[1] && !bus.Status[2];
            4'b1001: cond_ok = !bus.Status[1] || bus.Status[2];
            4'b1010: cond_ok = bus.Status[3] == bus.Status[0];
            4'b1011: cond_ok = bus.Status[3] != bus.Status[0];
            4'b1100: cond_ok = !bus.Status[2] && (bus.Status[3] == bus.Status[0]);
            4'b1101: cond_ok = bus.Status[2] || (bus.Status[3] != bus.Status[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign src1_used = !((mode == 2'b10) ||
                         (mode == 2'b00 && (opcode == OpMov || opcode == OpMvn)));
    assign src2_used = is_str || (mode == 2'b00 && !i_bit);
    assign hit1 = (bus.EXE_WB_EN && bus.EXE_Dest == rn) || (bus.MEM_WB_EN && bus.MEM_Dest == rn);
    assign hit2 = (bus.EXE_WB_EN && bus.EXE_Dest == src2) ||
                  (bus.MEM_WB_EN && bus.MEM_Dest == src2);
    assign hazard  = cond_ok && ((src1_used && hit1) || (src2_used && hit2));
    assign ctrl_ok = cond_ok && !hazard;

    assign bus.Wb_EN         = wb && ctrl_ok;
    assign bus.MEM_R_EN      = mr && ctrl_ok;
    assign bus.MEM_W_EN      = mw && ctrl_ok;
    assign bus.B             = br && ctrl_ok;
    assign bus.S             = sf && ctrl_ok;
    assign bus.EXE_CMD       = cmd;
    assign bus.PC            = bus.PC_IN;
    assign bus.Val_Rn        = val_rn;
    assign bus.Val_Rm        = val_rm;
    assign bus.imm           = i_bit;
    assign bus.Shift_operand = bus.Instruction[11:0];
    assign bus.Signed_imm_24 = bus.Instruction[23:0];
    assign bus.Dest          = rd;
    assign bus.C_out         = bus.Status[1];
    assign bus.Hazard        = hazard;
endmodule
